ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-cycle CPU.
- Owns the program counter and drives the word address of the combinational instruction ROM (128 x 32, 7-bit word address).
- Presents the fetched word to decode and computes next-PC from sequential, branch and jump inputs.
- Provides run/halt/single-step control and detects fetches outside the ROM.

Parameters:
- ADDR_W, 7, ROM word-address width; ROM depth is 2**ADDR_W words.
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  pulse; IDLE/HALT -> RUN.
- halt_req  in  1  level; stop after the current instruction retires.
- step_req  in  1  pulse; in HALT, retire exactly one instruction.
- stall  in  1  hold the current instruction (datapath busy).
- branch_taken  in  1  current instruction is a taken branch.
- branch_off  in  16  signed word offset (instr[15:0]).
- jump  in  1  current instruction is J.
- jump_tgt  in  26  instr[25:0].
- rom_addr  out  ADDR_W  ROM word address.
- rom_data  in  32  ROM output, combinational from rom_addr.
- instr  out  32  instruction to decode.
- instr_valid  out  1  instr retires this cycle when stall=0.
- pc  out  32  byte PC of instr.
- halted  out  1  FSM is in HALT.
- fault  out  1  sticky out-of-range fetch.
- ret_cnt  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, fault=0, halted=0, instr_valid=0, ret_cnt=0.
- rom_addr = pc[ADDR_W+1:2], combinational. instr = rom_data when instr_valid=1, else 32'h0 (NOP).
- FSM states: IDLE, RUN, HALT, STEP, FAULT.
  - IDLE: instr_valid=0; run -> RUN.
  - RUN: instr_valid=1. Retire = instr_valid & ~stall. On retire, pc <= npc. If halt_req=1 at retire -> HALT.
  - HALT: halted=1, instr_valid=0, pc held. run -> RUN. step_req -> STEP. run has priority over step_req.
  - STEP: instr_valid=1 for one or more cycles until retire; on retire pc <= npc, then -> HALT. halt_req is ignored in STEP.
  - FAULT: instr_valid=0, fault=1, pc holds the offending value. Exited only by reset.
- Next-PC (32-bit wrap arithmetic), with p4 = pc+4:
  - jump: npc = {p4[31:28], jump_tgt, 2'b00}. Jump has priority over branch_taken.
  - branch_taken: npc = p4 + (sext(branch_off) << 2).
  - otherwise: npc = p4.
- stall=1: pc, state and all counters hold. branch_taken, jump and halt_req are not acted on that cycle; they are re-sampled on the retiring cycle.
- Range check on retire: if npc[31:ADDR_W+2] != 0, enter FAULT instead of the normal next state, with pc <= npc. This includes the wrap of p4 past the last ROM word (pc = 4*(2**ADDR_W - 1), no branch/jump).
- Simultaneous events:
  - halt_req plus jump on retire: jump target is taken, then HALT.
  - run with halt_req already high: RUN lasts one retiring cycle, then HALT.
  - Reset mid-operation: immediate return to reset values; an instruction in flight is not retired.

Optional Feature:
- Macro IFETCH_RETCNT_EN.
- Defined: ret_cnt increments by 1 on every retire, saturating at 32'hFFFF_FFFF, and is cleared only by reset.
- Undefined: ret_cnt is tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset, pulse run, rom_data follows a model of addr*4: pc sequence 0,4,8,C; rom_addr 0,1,2,3; instr_valid=1 from the first RUN cycle.
- At pc=0x20, branch_taken=1, branch_off=16'h0001 -> next pc=0x28. With branch_off=16'hFFFE -> next pc=0x1C.
- At pc=0xAC, jump=1, jump_tgt=26'h00000D -> next pc=0x34. Jump and branch together -> jump target wins.
- stall high for 3 cycles at pc=0x10 with branch_taken=1 -> pc stays 0x10 and ret_cnt is unchanged; the branch is applied on the first cycle stall=0.
- halt_req set at pc=0x08 -> retires, halted=1 with pc=0x0C. Two step_req pulses -> pc 0x10 then 0x14, halted after each. run -> resumes.
- Sequential fetch from pc=0x1FC (ADDR_W=7) -> FAULT, fault=1, pc=0x200, instr_valid=0. Assert rst_n low mid-FAULT -> pc=0, fault=0. With IFETCH_RETCNT_EN defined, ret_cnt equals the number of retires observed.

Source files
------------

// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: word-address bus between the fetch sequencer and the
// combinational instruction ROM. The fetch side drives the address; the ROM
// side returns the addressed word in the same cycle.
interface ifetch_ctrl_if #(
   parameter int ADDR_W = 7
);
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer for the single-cycle CPU.
// Owns the PC, addresses the ROM, hands the fetched word to decode, computes
// the next PC (sequential / branch / jump) and runs the IDLE/RUN/HALT/STEP/
// FAULT control FSM. A fetch whose next PC leaves the ROM is sticky-faulted.
// Optional feature: define IFETCH_RETCNT_EN to build the saturating
// retired-instruction counter; otherwise ret_cnt is tied to zero.
module ifetch_ctrl #(
   parameter int          ADDR_W   = 7,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               halt_req,
   input  logic               step_req,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic signed [15:0] branch_off,
   input  logic               jump,
   input  logic        [25:0] jump_tgt,
   ifetch_ctrl_if.master      bus,
   output logic        [31:0] instr,
   output logic               instr_valid,
   output logic        [31:0] pc,
   output logic               halted,
   output logic               fault,
   output logic        [31:0] ret_cnt
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RUN   = 3'd1;
   localparam logic [2:0] HALT  = 3'd2;
   localparam logic [2:0] STEP  = 3'd3;
   localparam logic [2:0] FAULT = 3'd4;

   logic [2:0]         state;
   logic [31:0]        p4;
   logic [31:0]        npc;
   logic signed [31:0] br_disp;
   logic               retire;
   logic               out_of_range;

   // Signed word offset converted to a byte displacement.
   function automatic logic signed [31:0] word_off_to_bytes(input logic signed [15:0] off);
      logic signed [31:0] ext;
      ext = 32'(off);
      return ext <<< 2;
   endfunction

   assign bus.rom_addr = pc[ADDR_W+1:2];
   assign instr_valid  = (state == RUN) || (state == STEP);
   assign instr        = instr_valid ? bus.rom_data : 32'h0;
   assign halted       = (state == HALT);
   assign fault        = (state == FAULT);
   assign retire       = instr_valid & ~stall;

   // Next-PC selection: jump beats branch, otherwise fall through to pc+4.
   always_comb begin
      p4      = pc + 32'd4;
      br_disp = word_off_to_bytes(branch_off);
      npc     = p4;
      if (jump)
         npc = {p4[31:28], jump_tgt, 2'b00};
      else if (branch_taken)
         npc = p4 + br_disp;
      out_of_range = |npc[31:ADDR_W+2];
   end

   // Control FSM and PC update; the PC only moves on a retiring cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         unique case (state)
            IDLE: if (run) state <= RUN;
            RUN, STEP: begin
               if (retire) begin
                  pc <= npc;
                  if (out_of_range)
                     state <= FAULT;
                  else if ((state == STEP) || halt_req)
                     state <= HALT;
                  else
                     state <= RUN;
               end
            end
            HALT: begin
               if (run)
                  state <= RUN;
               else if (step_req)
                  state <= STEP;
            end
            FAULT: state <= FAULT;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IFETCH_RETCNT_EN
   logic [31:0] ret_q;

   // Saturating increment so the count never wraps back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Retired-instruction counter, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ret_q <= 32'h0;
      else if (retire)
         ret_q <= sat_inc(ret_q);
   end

   assign ret_cnt = ret_q;
`else
   assign ret_cnt = 32'h0;
`endif

endmodule
